conv3x3_window_gen: RTL and testbench

Streaming window generator feeding the 3x3 multi-channel convolution core. Accepts one multi-channel pixel per handshake in raster order. Buffers two image lines per channel and emits every fully-populated 3x3xNUM_CHANNELS window, with no padding (valid-only convolution). It is the producer side of the core's data_in/valid_in interface and adds ready-based backpressure.

---
 rtl/conv3x3_window_gen.sv | 93 +++++++++
 tb/tb_conv3x3_window_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen: streams raster pixels through two line buffers into a registered 3x3xNUM_CHANNELS window (WIN_POS_EN adds win_row/win_col)
module conv3x3_window_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic                                   pix_sof,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]     pix_data,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [NUM_CHANNELS*9*DATA_WIDTH-1:0]   win_data,
  output logic                                   frame_done
`ifdef WIN_POS_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0]          win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]           win_col
`endif
);
  localparam int PW = NUM_CHANNELS*DATA_WIDTH;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  logic [PW-1:0] lb0 [IMG_WIDTH];
  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic [PW-1:0] sr [3][3];
  logic [PW-1:0] nw [3][3];
  logic [PW-1:0] lb0_q, lb1_q;
  logic [RW-1:0] row, cur_row;
  logic [CW-1:0] col, cur_col;
  logic acc, emit, last, eol;
  logic [NUM_CHANNELS*9*DATA_WIDTH-1:0] win_next;
  assign pix_ready = !win_valid || win_ready;
  always_comb begin
    acc     = pix_valid && pix_ready;
    cur_row = pix_sof ? '0 : row;
    cur_col = pix_sof ? '0 : col;
    eol     = cur_col == CW'(IMG_WIDTH-1);
    last    = eol && cur_row == RW'(IMG_HEIGHT-1);
    emit    = acc && cur_row >= RW'(2) && cur_col >= CW'(2);
    lb0_q   = lb0[cur_col];
    lb1_q   = lb1[cur_col];
  end
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar k = 0; k < 3; k++) begin : g_col
      if (k < 2) begin : g_shift
        assign nw[r][k] = sr[r][k+1];
      end else begin : g_new
        assign nw[r][k] = r == 0 ? lb1_q : r == 1 ? lb0_q : pix_data;
      end
      for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign win_next[((c*9)+(r*3)+k)*DATA_WIDTH +: DATA_WIDTH] = nw[r][k][c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[cur_col] <= lb0_q;
      lb0[cur_col] <= pix_data;
      sr           <= nw;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      frame_done <= 1'b0;
`ifdef WIN_POS_EN
      win_row    <= '0;
      win_col    <= '0;
`endif
    end else begin
      frame_done <= acc && last;
      win_valid  <= emit || (win_valid && !win_ready);
      if (emit) win_data <= win_next;
      if (acc) begin
        col <= eol ? '0 : cur_col + 1'b1;
        row <= !eol ? cur_row : last ? '0 : cur_row + 1'b1;
      end
`ifdef WIN_POS_EN
      if (emit) begin
        win_row <= cur_row - 1'b1;
        win_col <= cur_col - 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_conv3x3_window_gen.sv
// tb_conv3x3_window_gen: directed and random streams checked against an image-array reference model
module tb_conv3x3_window_gen;
  localparam int DW = 8, NC = 2, W = 5, H = 4;
  localparam int PW = NC*DW, WD = NC*9*DW, NWIN = (W-2)*(H-2);
  logic clk = 0, rst_n = 0, pix_valid = 0, pix_sof = 0, win_ready = 0;
  logic pix_ready, win_valid, frame_done;
  logic [PW-1:0] pix_data = '0;
  logic [WD-1:0] win_data;
`ifdef WIN_POS_EN
  logic [$clog2(H)-1:0] win_row;
  logic [$clog2(W)-1:0] win_col;
`endif
  int n_tests = 0, n_fail = 0, n_win = 0, n_done = 0;
  logic [PW-1:0] img [H][W];
  logic m_valid = 0, m_done = 0;
  logic [WD-1:0] m_win = '0;
  int rpos = 0, cpos = 0, m_r = 0, m_c = 0;
  always #5 clk = ~clk;
  conv3x3_window_gen #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_data(pix_data), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
`ifdef WIN_POS_EN
    .win_row(win_row), .win_col(win_col),
`endif
    .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic logic [PW-1:0] ramp(input int p);
    for (int ch = 0; ch < NC; ch++) ramp[ch*DW +: DW] = DW'(p + 16*ch);
  endfunction
  task automatic cycle(input bit rst, input bit v, input bit sof, input bit wr, input logic [PW-1:0] d);
    bit acc, hs;
    @(negedge clk);
    rst_n = !rst; pix_valid = v; pix_sof = sof; pix_data = d; win_ready = wr;
    #1;
    chk("pix_ready", pix_ready, !m_valid || wr);
    if (win_valid && win_ready) n_win++;
    acc = !rst && v && (!m_valid || wr);
    hs  = m_valid && wr;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_done = 0; m_win = '0; rpos = 0; cpos = 0; m_r = 0; m_c = 0;
    end else begin
      m_done = 0;
      if (hs) m_valid = 0;
      if (acc) begin
        if (sof) begin rpos = 0; cpos = 0; end
        img[rpos][cpos] = d;
        if (rpos >= 2 && cpos >= 2) begin
          for (int ch = 0; ch < NC; ch++)
            for (int rr = 0; rr < 3; rr++)
              for (int kk = 0; kk < 3; kk++)
                m_win[((ch*9)+(rr*3)+kk)*DW +: DW] = img[rpos-2+rr][cpos-2+kk][ch*DW +: DW];
          m_valid = 1; m_r = rpos - 1; m_c = cpos - 1;
        end
        m_done = rpos == H-1 && cpos == W-1;
        cpos++;
        if (cpos == W) begin cpos = 0; rpos = (rpos + 1) % H; end
      end
    end
    #1;
    chk("win_valid", win_valid, m_valid);
    chk("frame_done", frame_done, m_done);
    if (frame_done) n_done++;
    if (m_valid) begin
      chk("win_data", win_data, m_win);
`ifdef WIN_POS_EN
      chk("win_row", win_row, m_r);
      chk("win_col", win_col, m_c);
`endif
    end
  endtask
  task automatic full_frame(input bit sgn);
    for (int p = 1; p <= W*H; p++) cycle(0, 1, p == 1, 1, sgn ? {NC{8'h80}} : ramp(p));
    repeat (2) cycle(0, 0, 0, 1, '0);
  endtask
  initial begin
    int bw, bd, p, stall;
    bit wr, ok;
    repeat (2) cycle(1, 0, 0, 1, '0);
    chk("rst_data", win_data, '0);
    bw = n_win; bd = n_done;
    full_frame(0);
    chk("ramp_windows", n_win - bw, NWIN);
    chk("ramp_done", n_done - bd, 1);
    bw = n_win; bd = n_done;
    full_frame(1);
    chk("signed_windows", n_win - bw, NWIN);
    chk("signed_done", n_done - bd, 1);
    bw = n_win; bd = n_done; p = 1; stall = 0;
    for (int i = 0; i < 200 && p <= W*H; i++) begin
      wr = !(m_valid && stall < 6);
      if (!wr) stall++;
      ok = !m_valid || wr;
      cycle(0, 1, p == 1, wr, ramp(p));
      if (ok) p++;
    end
    repeat (2) cycle(0, 0, 0, 1, '0);
    chk("bp_stalled", stall, 6);
    chk("bp_windows", n_win - bw, NWIN);
    chk("bp_done", n_done - bd, 1);
    bw = n_win; bd = n_done;
    for (int q = 1; q <= 10; q++) cycle(0, 1, q == 6, 1, ramp(q + 40));
    full_frame(0);
    chk("resync_windows", n_win - bw, NWIN);
    chk("resync_done", n_done - bd, 1);
    for (int q = 1; q <= 13; q++) cycle(0, 1, q == 1, 0, ramp(q + 60));
    chk("pre_rst_valid", win_valid, 1);
    cycle(1, 1, 0, 0, ramp(99));
    chk("mid_rst_data", win_data, '0);
    bw = n_win; bd = n_done;
    full_frame(0);
    chk("rst_windows", n_win - bw, NWIN);
    chk("rst_done", n_done - bd, 1);
    repeat (1500)
      cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, PW'($urandom));
    repeat (3) cycle(0, 0, 0, 1, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
